// File: rtl/adc_emu_pkg.sv
// Shared types and constants for the DDR ADC output emulator.
package adc_emu_pkg;

  typedef enum logic [1:0] {
    MODE_FIXED  = 2'd0,
    MODE_RAMP   = 2'd1,
    MODE_PRBS   = 2'd2,
    MODE_SQUARE = 2'd3
  } mode_e;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Feedback taps s7 ^ s5 ^ s4 ^ s3 (maximal length, period 255).
  localparam logic [7:0] PRBS8_TAPS = 8'b1011_1000;

  function automatic logic [7:0] prbs8_next(input logic [7:0] s);
    return {s[6:0], ^(s & PRBS8_TAPS)};
  endfunction

endpackage

// File: rtl/adc_emu_if.sv
// Configuration, control/status and emulated ADC bus of adc_emu_tx.
interface adc_emu_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic [1:0]        mode;
  logic [DATA_W-1:0] fixed_val;
  logic [DATA_W-1:0] step;
  logic [DATA_W-1:0] sq_lo;
  logic [DATA_W-1:0] sq_hi;
  logic [CNT_W-1:0]  sq_half;
  logic [CNT_W-1:0]  burst_len;
  logic              start;
  logic              stop;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  sample_cnt;
  logic              adc_dco;
  logic [DATA_W-1:0] adc_da;
  logic [DATA_W-1:0] adc_db;

  modport master (
    output mode, fixed_val, step, sq_lo, sq_hi, sq_half, burst_len, start, stop,
    input  busy, done, sample_cnt, adc_dco, adc_da, adc_db
  );

  modport slave (
    input  mode, fixed_val, step, sq_lo, sq_hi, sq_half, burst_len, start, stop,
    output busy, done, sample_cnt, adc_dco, adc_da, adc_db
  );
endinterface

// File: rtl/adc_emu_patgen.sv
// Pattern generator: latches its configuration on load, presents the current
// sample on a register and steps to the next one on advance.
module adc_emu_patgen
  import adc_emu_pkg::*;
#(
  parameter int         DATA_W    = 8,
  parameter int         CNT_W     = 16,
  parameter logic [7:0] LFSR_SEED = 8'h01
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fixed_val,
  input  logic [DATA_W-1:0] step,
  input  logic [DATA_W-1:0] sq_lo,
  input  logic [DATA_W-1:0] sq_hi,
  input  logic [CNT_W-1:0]  sq_half,
  output logic [DATA_W-1:0] sample
);

  mode_e             mode_reg;
  logic [DATA_W-1:0] step_reg;
  logic [DATA_W-1:0] sq_lo_reg;
  logic [DATA_W-1:0] sq_hi_reg;
  logic [CNT_W-1:0]  half_reg;
  logic [CNT_W-1:0]  phase_reg;
  logic              level_reg;
  logic [7:0]        lfsr_reg;
  logic [DATA_W-1:0] sample_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg   <= MODE_FIXED;
      step_reg   <= '0;
      sq_lo_reg  <= '0;
      sq_hi_reg  <= '0;
      half_reg   <= CNT_W'(1);
      phase_reg  <= '0;
      level_reg  <= 1'b0;
      lfsr_reg   <= LFSR_SEED;
      sample_reg <= '0;
    end else if (load) begin
      mode_reg  <= mode_e'(mode);
      step_reg  <= step;
      sq_lo_reg <= sq_lo;
      sq_hi_reg <= sq_hi;
      // A zero half-period behaves as one sample per level.
      half_reg  <= (sq_half == '0) ? CNT_W'(1) : sq_half;
      phase_reg <= '0;
      level_reg <= 1'b0;
      lfsr_reg  <= LFSR_SEED;
      case (mode_e'(mode))
        MODE_PRBS:   sample_reg <= DATA_W'(LFSR_SEED);
        MODE_SQUARE: sample_reg <= sq_lo;
        default:     sample_reg <= fixed_val;
      endcase
    end else if (advance) begin
      case (mode_reg)
        MODE_RAMP: sample_reg <= sample_reg + step_reg;
        MODE_PRBS: begin
          lfsr_reg   <= prbs8_next(lfsr_reg);
          sample_reg <= DATA_W'(prbs8_next(lfsr_reg));
        end
        MODE_SQUARE: begin
          if (phase_reg == half_reg - CNT_W'(1)) begin
            phase_reg  <= '0;
            level_reg  <= ~level_reg;
            sample_reg <= level_reg ? sq_lo_reg : sq_hi_reg;
          end else begin
            phase_reg <= phase_reg + CNT_W'(1);
          end
        end
        default: sample_reg <= sample_reg;
      endcase
    end
  end

  assign sample = sample_reg;

endmodule

// File: rtl/adc_emu_tx.sv
// Emulated 8-bit DDR ADC transmitter: burst/continuous control FSM and
// steering of generated samples onto the A (dco high) and B (dco low) lanes.
module adc_emu_tx
  import adc_emu_pkg::*;
#(
  parameter int         DATA_W    = 8,
  parameter int         CNT_W     = 16,
  parameter logic [7:0] LFSR_SEED = 8'h01
) (
  input logic       clk,
  input logic       rst_n,
  adc_emu_if.slave  bus
);

  state_t            state_reg;
  logic              dco_reg;
  logic [DATA_W-1:0] da_reg;
  logic [DATA_W-1:0] db_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  burst_len_reg;
  logic [DATA_W-1:0] sample;
  logic [CNT_W-1:0]  cnt_next;
  logic              load;
  logic              advance;

  assign load     = (state_reg == ST_IDLE) && bus.start && !bus.stop;
  assign advance  = (state_reg == ST_RUN) && !bus.stop;
  assign cnt_next = cnt_reg + CNT_W'(1);

  adc_emu_patgen #(
    .DATA_W    (DATA_W),
    .CNT_W     (CNT_W),
    .LFSR_SEED (LFSR_SEED)
  ) u_patgen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .advance   (advance),
    .mode      (bus.mode),
    .fixed_val (bus.fixed_val),
    .step      (bus.step),
    .sq_lo     (bus.sq_lo),
    .sq_hi     (bus.sq_hi),
    .sq_half   (bus.sq_half),
    .sample    (sample)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      dco_reg       <= 1'b0;
      da_reg        <= '0;
      db_reg        <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      cnt_reg       <= '0;
      burst_len_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          dco_reg <= 1'b0;
          if (load) begin
            state_reg     <= ST_RUN;
            busy_reg      <= 1'b1;
            cnt_reg       <= '0;
            burst_len_reg <= bus.burst_len;
          end
        end
        ST_RUN: begin
          if (bus.stop) begin
            // Abort: no sample on this edge, count is kept for inspection.
            state_reg <= ST_IDLE;
            dco_reg   <= 1'b0;
            busy_reg  <= 1'b0;
          end else begin
            dco_reg <= ~dco_reg;
            if (!dco_reg) da_reg <= sample;
            else          db_reg <= sample;
            cnt_reg <= cnt_next;
            if ((burst_len_reg != '0) && (cnt_next == burst_len_reg)) begin
              state_reg <= ST_DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
          dco_reg   <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          dco_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.sample_cnt = cnt_reg;
  assign bus.adc_dco    = dco_reg;
  assign bus.adc_da     = da_reg;
  assign bus.adc_db     = db_reg;

endmodule
